// File: rtl/pe_psum_packetizer.sv
// Wraps partial sums from the PE split stage into NoC packets {dest, src, last, seq, payload}.
// Optional build macro PKT_PARITY_EN appends an even-parity bit as packet bit 0.
module pe_psum_packetizer #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned SEQ_W      = 4,
    parameter int unsigned SRC_ADDR   = 1,
    parameter int unsigned DEST_ADDR  = 3,
    parameter int unsigned ROW_LEN    = 4,
    parameter int unsigned FIFO_DEPTH = 2,
`ifdef PKT_PARITY_EN
    localparam int unsigned PAR_W     = 1,
`else
    localparam int unsigned PAR_W     = 0,
`endif
    localparam int unsigned PKT_W     = 2*ADDR_W + 1 + SEQ_W + DWIDTH + PAR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] psum_data,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              pkt_valid,
    input  logic              pkt_ready
);

    localparam int unsigned RAW_W = PKT_W - PAR_W;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ROW_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SEQ_W-1:0]  seq_q;
    logic [ROW_W-1:0]  row_q;
    logic [PKT_W-1:0]  pkt_q, pkt_d;
    state_e            state_q;

    logic              fifo_full, fifo_empty;
    logic              push, pop, row_last;
    logic [RAW_W-1:0]  raw_pkt;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = psum_valid && !fifo_full;
    // A pop always means the output register is (or is about to be) free.
    assign pop        = !fifo_empty && ((state_q == ST_EMPTY) || pkt_ready);
    assign row_last   = (row_q == ROW_W'(ROW_LEN - 1));

    assign raw_pkt = {ADDR_W'(DEST_ADDR), ADDR_W'(SRC_ADDR), row_last, seq_q, mem_q[rd_ptr_q]};
`ifdef PKT_PARITY_EN
    assign pkt_d   = {raw_pkt, ^raw_pkt};
`else
    assign pkt_d   = raw_pkt;
`endif

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= psum_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            seq_q    <= '0;
            row_q    <= '0;
            pkt_q    <= '0;
            state_q  <= ST_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            case (state_q)
                ST_EMPTY: begin
                    if (pop) begin
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (pkt_ready && !pop) begin
                        state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
            // Every pop loads the output register and advances seq/row counters.
            if (pop) begin
                pkt_q <= pkt_d;
                seq_q <= seq_q + SEQ_W'(1);
                row_q <= row_last ? '0 : row_q + ROW_W'(1);
            end
        end
    end

    assign pkt_data   = pkt_q;
    assign pkt_valid  = (state_q == ST_FULL);
    assign psum_ready = !fifo_full;

endmodule

// File: tb/tb_pe_psum_packetizer.sv
// Scoreboard bench for pe_psum_packetizer: driver queues expected packets, monitor pops and compares.
`timescale 1ns/1ps
module tb_pe_psum_packetizer;

`ifdef PKT_PARITY_EN
    localparam int unsigned PW = 22;
`else
    localparam int unsigned PW = 21;
`endif
    localparam int ROWL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    psum_data = 8'h00;
    logic          psum_valid = 1'b0;
    logic          psum_ready;
    logic [PW-1:0] pkt_data;
    logic          pkt_valid;
    logic          pkt_ready = 1'b1;

    pe_psum_packetizer dut (
        .clk       (clk),
        .rst       (rst),
        .psum_data (psum_data),
        .psum_valid(psum_valid),
        .psum_ready(psum_ready),
        .pkt_data  (pkt_data),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] rx_log[$];
    int   rx_cnt = 0;
    logic [3:0] m_seq = 4'd0;
    int   m_row = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Hand-computed 21-bit packet -> packet as seen in this build.
    function automatic logic [PW-1:0] hw(input logic [20:0] raw);
`ifdef PKT_PARITY_EN
        return {raw, ^raw};
`else
        return raw;
`endif
    endfunction

    task automatic push_exp(input logic [7:0] d);
        logic last;
        last = (m_row == ROWL - 1);
        exp_q.push_back(hw({4'd3, 4'd1, last, m_seq, d}));
        m_row = last ? 0 : m_row + 1;
        m_seq = m_seq + 4'd1;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        psum_data  = d;
        psum_valid = 1'b1;
        while (!psum_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!psum_ready) check("send_timeout", 32'(psum_ready), 32'd1);
        else push_exp(d);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        #2;
        check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
        check("rst_pkt_data", 32'(pkt_data), 32'd0);
        check("rst_psum_ready", 32'(psum_ready), 32'd1);
        psum_valid = 1'b0;
        exp_q.delete();
        rx_log.delete();
        m_seq = 4'd0;
        m_row = 0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #3;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: samples between edges, pops scoreboard on each transfer.
    initial begin
        logic          hold;
        logic [PW-1:0] hold_data;
        logic [PW-1:0] e;
        hold = 1'b0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) check("hold_stable", 32'({pkt_valid, pkt_data}), 32'({1'b1, hold_data}));
                if (pkt_valid && pkt_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_pkt: got 0x%0h expected none", pkt_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("pkt", 32'(pkt_data), 32'(e));
                    end
                    rx_log.push_back(pkt_data);
                    rx_cnt++;
                end
                hold      = pkt_valid && !pkt_ready;
                hold_data = pkt_data;
            end
        end
    end

    initial begin
        int base;
        #3;
        check("init_pkt_valid", 32'(pkt_valid), 32'd0);
        check("init_psum_ready", 32'(psum_ready), 32'd1);
        do_reset();

        // Single psum and its latency.
        send(8'h5A);
        @(negedge clk);
        psum_valid = 1'b0;
        #1 check("lat_n1_valid", 32'(pkt_valid), 32'd0);
        @(negedge clk);
        #1 check("lat_n2_valid", 32'(pkt_valid), 32'd1);
        check("single_data", 32'(pkt_data), 32'(hw(21'h6205A)));
        @(negedge clk);
        #3 check("single_done", 32'(pkt_valid), 32'd0);

        // Backpressure: three fill the buffer, the fourth is held off.
        do_reset();
        pkt_ready = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        @(negedge clk);
        psum_data  = 8'h04;
        psum_valid = 1'b1;
        #1 check("bp_full_ready", 32'(psum_ready), 32'd0);
        repeat (10) begin
            @(negedge clk);
            #1 check("bp_hold_data", 32'(pkt_data), 32'(hw(21'h62001)));
            check("bp_hold_ready", 32'(psum_ready), 32'd0);
        end
        @(negedge clk);
        pkt_ready = 1'b1;
        base = rx_cnt;
        @(negedge clk);
        #1 check("bp_space_ready", 32'(psum_ready), 32'd1);
        push_exp(8'h04);
        @(negedge clk);
        psum_valid = 1'b0;
        @(negedge clk);
        #3 check("bp_back_to_back", 32'(rx_cnt - base), 32'd4);
        drain();

        // Row-last flag over two rows.
        do_reset();
        for (int i = 1; i <= 8; i++) send(8'(i));
        idle();
        drain();
        check("row_count", 32'(rx_log.size()), 32'd8);
        if (rx_log.size() == 8) begin
            check("row_pkt1", 32'(rx_log[0]), 32'(hw(21'h62001)));
            check("row_pkt4", 32'(rx_log[3]), 32'(hw(21'h63304)));
            check("row_pkt5", 32'(rx_log[4]), 32'(hw(21'h62405)));
            check("row_pkt8", 32'(rx_log[7]), 32'(hw(21'h63708)));
        end

        // Sequence wrap.
        do_reset();
        for (int i = 1; i <= 17; i++) send(8'(i));
        idle();
        drain();
        check("wrap_count", 32'(rx_log.size()), 32'd17);
        if (rx_log.size() == 17) begin
            check("wrap_pkt16", 32'(rx_log[15]), 32'(hw(21'h63F10)));
            check("wrap_pkt17", 32'(rx_log[16]), 32'(hw(21'h62011)));
        end

        // Reset with psums buffered discards them.
        do_reset();
        pkt_ready = 1'b0;
        send(8'hA1);
        send(8'hA2);
        idle();
        do_reset();
        pkt_ready = 1'b1;
        base = rx_cnt;
        repeat (10) @(negedge clk);
        #3 check("rst_flush_cnt", 32'(rx_cnt - base), 32'd0);
        check("rst_flush_valid", 32'(pkt_valid), 32'd0);

`ifdef PKT_PARITY_EN
        do_reset();
        send(8'h5A);
        idle();
        drain();
        if (rx_log.size() == 1) check("par_5a", 32'(rx_log[0]), 32'(hw(21'h6205A)));
        do_reset();
        send(8'h5B);
        idle();
        drain();
        if (rx_log.size() == 1) check("par_5b", 32'(rx_log[0]), 32'(hw(21'h6205B)));
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
